// File: rtl/kernel_loader.sv
// kernel_loader: front-door writer for the classifier's kernel load port.
// Consumes a valid/ready stream of DW-bit words and turns each accepted word
// into one registered write into the conv1, conv2 and FC parameter memories.
// The order is fixed: conv1 kernels (90), conv1 offsets (18), conv2 kernels
// (1080), conv2 offsets (60), FC chunks (10 nodes x FC_WPN).
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a DW-bit wrapping sum of every accepted data word is kept.
//   One extra checksum word is accepted after the FC chunks. A mismatch sets
//   a sticky err that is cleared by the next start.
//   When undefined, there is no checksum word and err is tied 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a load sequence (honoured only when idle)
//   s_valid/s_ready     stream handshake; s_ready is high in load states only
//   s_data[DW]          stream word
//   kernel_in_valid     one-cycle write strobe
//   kernel_layer[2]     1=conv1, 2=conv2, 3=fc
//   kernel_is_offset    write targets the offset memory
//   kernel_addr[11]     memory index within the current section
//   kernel_data[DW]     kernel / FC chunk payload (0 on offset writes)
//   kernel_offset[OW]   offset payload (0 on kernel writes)
//   busy                sequence in progress
//   done                one-cycle completion pulse
//   err                 checksum mismatch (sticky)
module kernel_loader #(
    parameter int unsigned DW     = 25,
    parameter int unsigned OW     = 9,
    parameter int unsigned FC_WPN = 39
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          kernel_in_valid,
    output logic [1:0]    kernel_layer,
    output logic          kernel_is_offset,
    output logic [10:0]   kernel_addr,
    output logic [DW-1:0] kernel_data,
    output logic [OW-1:0] kernel_offset,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned AW    = 11;
    localparam int unsigned C1K_N = 90;
    localparam int unsigned C1B_N = 18;
    localparam int unsigned C2K_N = 1080;
    localparam int unsigned C2B_N = 60;
    localparam int unsigned FCW_N = 10 * FC_WPN;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_C1K, S_C1B, S_C2K, S_C2B, S_FCW, S_CHK, S_FIN
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_C1K, S_C1B, S_C2K, S_C2B, S_FCW, S_FIN
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            s_ready_q, s_ready_d;
    logic            valid_q, valid_d;
    logic [1:0]      layer_q, layer_d;
    logic            is_off_q, is_off_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [OW-1:0]   offset_q, offset_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
    logic            err_q, err_d;
    logic [DW-1:0]   sum_q, sum_d;
`endif

    logic            accept;
    logic            in_load;
    logic [1:0]      cur_layer;
    logic            cur_off;
    logic [AW-1:0]   cur_last;
    state_e          cur_next;

    assign accept = s_valid && s_ready_q;

    // Per-section write attributes: target layer/memory, last index, successor.
    always_comb begin
        in_load   = 1'b0;
        cur_layer = 2'd0;
        cur_off   = 1'b0;
        cur_last  = '0;
        cur_next  = S_IDLE;
        case (state_q)
            S_C1K: begin
                in_load   = 1'b1;
                cur_layer = 2'd1;
                cur_last  = AW'(C1K_N - 1);
                cur_next  = S_C1B;
            end
            S_C1B: begin
                in_load   = 1'b1;
                cur_layer = 2'd1;
                cur_off   = 1'b1;
                cur_last  = AW'(C1B_N - 1);
                cur_next  = S_C2K;
            end
            S_C2K: begin
                in_load   = 1'b1;
                cur_layer = 2'd2;
                cur_last  = AW'(C2K_N - 1);
                cur_next  = S_C2B;
            end
            S_C2B: begin
                in_load   = 1'b1;
                cur_layer = 2'd2;
                cur_off   = 1'b1;
                cur_last  = AW'(C2B_N - 1);
                cur_next  = S_FCW;
            end
            S_FCW: begin
                in_load   = 1'b1;
                cur_layer = 2'd3;
                cur_last  = AW'(FCW_N - 1);
`ifdef LOADER_CHECKSUM_EN
                cur_next  = S_CHK;
`else
                cur_next  = S_FIN;
`endif
            end
            default: ;
        endcase
    end

    // Next state, index and registered write fields.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = 1'b0;
        layer_d  = 2'd0;
        is_off_d = 1'b0;
        addr_d   = '0;
        data_d   = '0;
        offset_d = '0;
`ifdef LOADER_CHECKSUM_EN
        err_d    = err_q;
        sum_d    = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_C1K;
                    idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
                    sum_d   = '0;
`endif
                end
            end
            S_FIN: state_d = S_IDLE;
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    err_d   = (s_data != sum_q);
                    state_d = S_FIN;
                end
            end
`endif
            default: begin
                if (in_load && accept) begin
                    valid_d  = 1'b1;
                    layer_d  = cur_layer;
                    is_off_d = cur_off;
                    addr_d   = idx_q;
                    if (cur_off) begin
                        offset_d = s_data[OW-1:0];
                    end else begin
                        data_d   = s_data;
                    end
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = sum_q + s_data;
`endif
                    if (idx_q == cur_last) begin
                        state_d = cur_next;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                    end
                end
            end
        endcase
        // Status flags follow the state being entered so they line up with it.
        busy_d    = (state_d != S_IDLE);
        s_ready_d = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d    = (state_d == S_FIN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            s_ready_q <= 1'b0;
            valid_q   <= 1'b0;
            layer_q   <= 2'd0;
            is_off_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            offset_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err_q     <= 1'b0;
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            s_ready_q <= s_ready_d;
            valid_q   <= valid_d;
            layer_q   <= layer_d;
            is_off_q  <= is_off_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            offset_q  <= offset_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef LOADER_CHECKSUM_EN
            err_q     <= err_d;
            sum_q     <= sum_d;
`endif
        end
    end

    assign s_ready          = s_ready_q;
    assign kernel_in_valid  = valid_q;
    assign kernel_layer     = layer_q;
    assign kernel_is_offset = is_off_q;
    assign kernel_addr      = addr_q;
    assign kernel_data      = data_q;
    assign kernel_offset    = offset_q;
    assign busy             = busy_q;
    assign done             = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign err              = err_q;
`else
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_loader.sv
// Bench for kernel_loader: directed steps with random data and random
// stream gaps, checked against a section-table reference model.
module tb_kernel_loader;

    localparam int unsigned DW = 25;
    localparam int unsigned OW = 9;
    localparam int ND = 1638;
`ifdef LOADER_CHECKSUM_EN
    localparam int NW = 1639;
`else
    localparam int NW = 1638;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          kernel_in_valid;
    logic [1:0]    kernel_layer;
    logic          kernel_is_offset;
    logic [10:0]   kernel_addr;
    logic [DW-1:0] kernel_data;
    logic [OW-1:0] kernel_offset;
    logic          busy;
    logic          done;
    logic          err;

    kernel_loader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .kernel_in_valid  (kernel_in_valid),
        .kernel_layer     (kernel_layer),
        .kernel_is_offset (kernel_is_offset),
        .kernel_addr      (kernel_addr),
        .kernel_data      (kernel_data),
        .kernel_offset    (kernel_offset),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    layer;
        logic          is_off;
        logic [10:0]   addr;
        logic [DW-1:0] data;
        logic [OW-1:0] offset;
    } wr_t;

    wr_t           seen[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic          err_at_done = 1'b0;
    int            cyc = 0;
    int            start_cyc = 0;
    logic [DW-1:0] words [0:1638];
    int            n_pass = 0;
    int            n_fail = 0;
    int            n_total = 0;

    // Edge counter; remembers the edge at which an idle loader took start.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start && !busy && rst_n) start_cyc <= cyc + 1;
    end

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (kernel_in_valid)
            seen.push_back('{kernel_layer, kernel_is_offset, kernel_addr, kernel_data, kernel_offset});
        if (done) begin
            done_cnt    <= done_cnt + 1;
            done_cyc    <= cyc;
            err_at_done <= err;
        end
    end

    // Expected write for stream word k: sections laid out back to back.
    function automatic wr_t model(input int k, input logic [DW-1:0] w);
        wr_t r;
        r = '0;
        if (k < 90) begin
            r.layer = 2'd1; r.addr = 11'(k); r.data = w;
        end else if (k < 108) begin
            r.layer = 2'd1; r.is_off = 1'b1; r.addr = 11'(k - 90); r.offset = w[OW-1:0];
        end else if (k < 1188) begin
            r.layer = 2'd2; r.addr = 11'(k - 108); r.data = w;
        end else if (k < 1248) begin
            r.layer = 2'd2; r.is_off = 1'b1; r.addr = 11'(k - 1188); r.offset = w[OW-1:0];
        end else begin
            r.layer = 2'd3; r.addr = 11'(k - 1248); r.data = w;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Data words plus, when enabled, the matching checksum word.
    task automatic set_checksum();
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < ND; k++) s = s + words[k];
        words[ND] = s;
    endtask

    task automatic fill_random();
        for (int k = 0; k < ND; k++) words[k] = DW'($urandom);
        set_checksum();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers words[0..n-1] with probability pct per cycle; start_at raises start with that word.
    task automatic feed(input int n, input int pct, input int start_at);
        int  i;
        int  budget;
        bit  v;
        bit  acc;
        i = 0;
        budget = 0;
        while (i < n && budget < 20000) begin
            v       = ($urandom_range(99) < pct);
            s_valid = v;
            s_data  = v ? words[i] : DW'($urandom);
            start   = (i == start_at);
            acc     = v && s_ready;
            @(negedge clk);
            if (acc) i++;
            budget++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        check("feed_words_accepted", 64'(i), 64'(n));
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 50 && busy; c++) @(negedge clk);
        check("returns_idle", 64'(busy), 64'(0));
    endtask

    task automatic verify(input string tag, input int b_seen, input int n_exp);
        int bad;
        int lim;
        bad = 0;
        lim = seen.size() - b_seen;
        if (lim > n_exp) lim = n_exp;
        for (int k = 0; k < lim; k++)
            if (seen[b_seen + k] !== model(k, words[k])) bad++;
        check({tag, "_strobe_count"}, 64'(seen.size() - b_seen), 64'(n_exp));
        check({tag, "_payload_errors"}, 64'(bad), 64'(0));
    endtask

    task automatic full_load(input string tag, input int pct);
        int b_seen;
        int b_done;
        b_seen = seen.size();
        b_done = done_cnt;
        do_start();
        feed(NW, pct, -1);
        wait_idle();
        verify(tag, b_seen, ND);
        check({tag, "_done_pulses"}, 64'(done_cnt - b_done), 64'(1));
        check({tag, "_err_at_done"}, 64'(err_at_done), 64'(0));
    endtask

    initial begin
        int b;
        wr_t w;

        // Reset and idle with s_valid high but no start.
        s_valid = 1'b1;
        s_data  = DW'(123);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_s_ready", 64'(s_ready), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_no_strobes", 64'(seen.size()), 64'(0));
        check("idle_outputs", 64'({kernel_in_valid, kernel_layer, kernel_is_offset, kernel_addr,
                                   kernel_offset, done, err}), 64'(0));
        check("idle_kernel_data", 64'(kernel_data), 64'(0));
        s_valid = 1'b0;

        // Full load, word k = k, s_valid held high.
        for (int k = 0; k < ND; k++) words[k] = DW'(k);
        set_checksum();
        b = seen.size();
        do_start();
        check("start_busy", 64'(busy), 64'(1));
        check("start_s_ready", 64'(s_ready), 64'(1));
        feed(NW, 100, -1);
        wait_idle();
        verify("incr", b, ND);
        check("incr_done_pulses", 64'(done_cnt), 64'(1));
        check("incr_start_to_done", 64'(done_cyc - start_cyc), 64'(NW));
        check("incr_err_at_done", 64'(err_at_done), 64'(0));
        w = seen[b];
        check("first_strobe", 64'({w.layer, w.is_off, w.addr, w.data}), 64'({2'd1, 1'b0, 11'd0, 25'd0}));
        w = seen[b + 90];
        check("strobe_91", 64'({w.layer, w.is_off, w.addr, w.offset, w.data}),
              64'({2'd1, 1'b1, 11'd0, 9'd90, 25'd0}));
        w = seen[b + ND - 1];
        check("last_strobe", 64'({w.layer, w.is_off, w.addr}), 64'({2'd3, 1'b0, 11'd389}));

        // Random data with random stream gaps.
        fill_random();
        full_load("gaps", 50);

        // start raised while C2K addr 500 is being written: ignored.
        fill_random();
        b = seen.size();
        do_start();
        feed(NW, 100, 608);
        wait_idle();
        verify("midstart", b, ND);
        w = seen[b + 609];
        check("midstart_next_addr", 64'({w.layer, w.is_off, w.addr}), 64'({2'd2, 1'b0, 11'd501}));

        // Reset dropped just after C2B addr 10 was accepted.
        fill_random();
        b = seen.size();
        do_start();
        feed(1199, 100, -1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_outputs", 64'({kernel_in_valid, kernel_layer, kernel_is_offset, kernel_addr,
                                  kernel_offset, busy, s_ready, done, err}), 64'(0));
        check("rst_kernel_data", 64'(kernel_data), 64'(0));
        verify("pre_rst", b, 1199);
        w = seen[b + 1198];
        check("pre_rst_last", 64'({w.layer, w.is_off, w.addr}), 64'({2'd2, 1'b1, 11'd10}));
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        full_load("after_rst", 75);

`ifdef LOADER_CHECKSUM_EN
        // Checksum: all ones, correct sum then a wrong sum.
        for (int k = 0; k < ND; k++) words[k] = DW'(1);
        words[ND] = DW'(1638);
        full_load("sum_ok", 100);
        check("sum_ok_err", 64'(err), 64'(0));
        b = done_cnt;
        words[ND] = DW'(1637);
        do_start();
        feed(NW, 100, -1);
        wait_idle();
        check("sum_bad_done", 64'(done_cnt - b), 64'(1));
        check("sum_bad_err_at_done", 64'(err_at_done), 64'(1));
        repeat (3) @(negedge clk);
        check("sum_bad_err_sticky", 64'(err), 64'(1));
        words[ND] = DW'(1638);
        b = seen.size();
        do_start();
        check("err_cleared_by_start", 64'(err), 64'(0));
        feed(NW, 100, -1);
        wait_idle();
        verify("sum_reload", b, ND);
        check("sum_reload_err", 64'(err), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
